// File: rtl/multi_debounce.sv
// N-channel push-button debouncer: per-channel 2-flop synchroniser, 4-state debounce FSM,
// registered rise/fall strobes and a single long-press (hold) strobe per press.
module multi_debounce #(
    parameter int                  CHANNELS        = 4,
    parameter int                  DEBOUNCE_CYCLES = 50000,
    parameter int                  HOLD_CYCLES     = 50000000,
    parameter logic [CHANNELS-1:0] INIT_VALUE      = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] signal_i,
    output logic [CHANNELS-1:0] signal_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] hold_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {ZERO, Z2O, ONE, O2Z} state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          sync_a;
        logic          sync_b;
        state_t        state;
        logic [CW-1:0] cnt;
        logic          level;
        logic          rise;
        logic          fall;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_a <= INIT_VALUE[i];
                sync_b <= INIT_VALUE[i];
                state  <= INIT_VALUE[i] ? ONE : ZERO;
                cnt    <= '0;
                level  <= INIT_VALUE[i];
                rise   <= 1'b0;
                fall   <= 1'b0;
            end else begin
                sync_a <= signal_i[i];
                sync_b <= sync_a;
                rise   <= 1'b0;
                fall   <= 1'b0;
                // A disagreeing sample always aborts, even on the cycle the count would complete.
                case (state)
                    ZERO: begin
                        if (sync_b) begin
                            state <= Z2O;
                            cnt   <= '0;
                        end
                    end
                    Z2O: begin
                        if (!sync_b) begin
                            state <= ZERO;
                        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                            state <= ONE;
                            level <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ONE: begin
                        if (!sync_b) begin
                            state <= O2Z;
                            cnt   <= '0;
                        end
                    end
                    O2Z: begin
                        if (sync_b) begin
                            state <= ONE;
                        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                            state <= ZERO;
                            level <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                endcase
            end
        end

        assign signal_o[i] = level;
        assign rise_o[i]   = rise;
        assign fall_o[i]   = fall;

        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

            logic [HW-1:0] hcnt;
            logic          held;
            logic          hold;

            // held starts set for a channel that resets high: that level is not a press.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hcnt <= '0;
                    held <= INIT_VALUE[i];
                    hold <= 1'b0;
                end else begin
                    hold <= 1'b0;
                    if (state == ONE || state == O2Z) begin
                        if (!held) begin
                            if (hcnt == HW'(HOLD_CYCLES - 1)) begin
                                hold <= 1'b1;
                                held <= 1'b1;
                            end else begin
                                hcnt <= hcnt + 1'b1;
                            end
                        end
                    end else begin
                        hcnt <= '0;
                        held <= 1'b0;
                    end
                end
            end

            assign hold_o[i] = hold;
        end else begin : g_nohold
            assign hold_o[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Scoreboard bench for multi_debounce: stimulus queues expected strobes and levels,
// a negedge monitor matches every DUT strobe and due level check against the queues.
module tb_multi_debounce;

    localparam int         CH   = 4;
    localparam int         DB   = 4;
    localparam int         HC   = 10;
    localparam logic [3:0] INIT = 4'b0100;
    localparam int         LAT  = DB + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] signal_i;
    logic [3:0] signal_o;
    logic [3:0] rise_o;
    logic [3:0] fall_o;
    logic [3:0] hold_o;

    multi_debounce #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC),
        .INIT_VALUE     (INIT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .signal_i(signal_i),
        .signal_o(signal_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .hold_o  (hold_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    typedef struct {
        int         cyc;
        int         what;
        logic [3:0] val;
    } lv_t;

    ev_t ev_q[$];
    lv_t lv_q[$];
    int  total = 0;
    int  bad   = 0;

    function automatic string kname(int k);
        if (k == 0) return "rise";
        if (k == 1) return "fall";
        return "hold";
    endfunction

    task automatic expect_ev(int at, int ch, int kind);
        ev_t e;
        e.cyc  = at;
        e.ch   = ch;
        e.kind = kind;
        ev_q.push_back(e);
    endtask

    // what: 0 = signal_o, 1 = OR of all strobes
    task automatic expect_lv(int at, int what, logic [3:0] val);
        lv_t l;
        l.cyc  = at;
        l.what = what;
        l.val  = val;
        lv_q.push_back(l);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [3:0] act;
        logic [3:0] sv;
        int         hit;
        for (int j = lv_q.size() - 1; j >= 0; j--) begin
            if (lv_q[j].cyc <= cyc) begin
                act = (lv_q[j].what == 0) ? signal_o : (rise_o | fall_o | hold_o);
                total++;
                if (lv_q[j].cyc != cyc || act !== lv_q[j].val) begin
                    bad++;
                    $display("FAIL %s @cycle %0d: got %b, required %b",
                             (lv_q[j].what == 0) ? "level" : "strobes", lv_q[j].cyc, act, lv_q[j].val);
                end
                lv_q.delete(j);
            end
        end
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                sv = (k == 0) ? rise_o : ((k == 1) ? fall_o : hold_o);
                for (int ch = 0; ch < CH; ch++) begin
                    if (sv[ch]) begin
                        hit = -1;
                        for (int j = 0; j < ev_q.size(); j++)
                            if (hit < 0 && ev_q[j].cyc == cyc && ev_q[j].ch == ch && ev_q[j].kind == k)
                                hit = j;
                        total++;
                        if (hit < 0) begin
                            bad++;
                            $display("FAIL %s ch%0d: pulse at cycle %0d, required none", kname(k), ch, cyc);
                        end else begin
                            ev_q.delete(hit);
                        end
                    end
                end
            end
        end
        for (int j = ev_q.size() - 1; j >= 0; j--) begin
            if (ev_q[j].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL %s ch%0d: no pulse at cycle %0d, required pulse at cycle %0d",
                         kname(ev_q[j].kind), ev_q[j].ch, cyc, ev_q[j].cyc);
                ev_q.delete(j);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n    = 1'b0;
        signal_i = INIT;

        // Reset: levels at INIT, no strobes, and quiet for 20 cycles after release
        tick(2);
        expect_lv(cyc, 0, INIT);
        expect_lv(cyc, 1, 4'b0000);
        tick(1);
        rst_n = 1'b1;
        expect_lv(cyc + 20, 0, INIT);
        tick(21);

        // Clean press and release on ch0
        c = cyc;
        signal_i[0] = 1'b1;
        expect_lv(c + LAT - 1, 0, INIT);
        expect_lv(c + LAT, 0, 4'b0101);
        expect_lv(c + LAT + 1, 1, 4'b0000);
        expect_ev(c + LAT, 0, 0);
        expect_ev(c + LAT + HC, 0, 2);
        tick(20);
        c = cyc;
        signal_i[0] = 1'b0;
        expect_lv(c + LAT, 0, INIT);
        expect_ev(c + LAT, 0, 1);
        tick(LAT + 2);

        // Bouncing press on ch1: 1,0,1,0 for 2 cycles each, then stable 1
        signal_i[1] = 1'b1;
        tick(2);
        signal_i[1] = 1'b0;
        tick(2);
        signal_i[1] = 1'b1;
        tick(2);
        signal_i[1] = 1'b0;
        tick(2);
        c = cyc;
        signal_i[1] = 1'b1;
        expect_lv(c + LAT - 1, 0, INIT);
        expect_lv(c + LAT, 0, 4'b0110);
        expect_ev(c + LAT, 1, 0);
        expect_ev(c + LAT + HC, 1, 2);
        tick(LAT + HC + 2);

        // Release ch2 (resets high): single fall, never a hold
        c = cyc;
        signal_i[2] = 1'b0;
        expect_lv(c + LAT - 1, 0, 4'b0110);
        expect_lv(c + LAT, 0, 4'b0010);
        expect_ev(c + LAT, 2, 1);
        tick(LAT + HC + 5);

        // Long press on ch3 held 30 cycles: one hold strobe 10 cycles after rise
        c = cyc;
        signal_i[3] = 1'b1;
        expect_lv(c + LAT, 0, 4'b1010);
        expect_ev(c + LAT, 3, 0);
        expect_ev(c + LAT + HC, 3, 2);
        tick(30);
        c = cyc;
        signal_i[3] = 1'b0;
        expect_lv(c + LAT, 0, 4'b0010);
        expect_ev(c + LAT, 3, 1);
        tick(LAT + 3);

        // Simultaneous fall on ch1 and press on ch2
        c = cyc;
        signal_i[1] = 1'b0;
        signal_i[2] = 1'b1;
        expect_lv(c + LAT, 0, INIT);
        expect_lv(c + LAT, 1, 4'b0110);
        expect_ev(c + LAT, 1, 1);
        expect_ev(c + LAT, 2, 0);
        expect_ev(c + LAT + HC, 2, 2);
        tick(LAT + HC + 3);

        // Half-cycle async reset while ch0 is mid-debounce; the press restarts from scratch
        c = cyc;
        signal_i[0] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        expect_lv(cyc, 0, INIT);
        expect_lv(cyc, 1, 4'b0000);
        #5;
        rst_n = 1'b1;
        expect_lv(cyc + LAT - 1, 0, INIT);
        expect_lv(cyc + LAT, 0, 4'b0101);
        expect_ev(cyc + LAT, 0, 0);
        expect_ev(cyc + LAT + HC, 0, 2);
        tick(LAT + HC + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
